// File: rtl/rev_alu_pkg.sv
// Shared definitions for the reversible ALU and its uncompute stage:
// opcode encodings, sequencer states and the invertibility predicate.
package rev_alu_pkg;

    localparam logic [2:0] SEL_ADD  = 3'b000;
    localparam logic [2:0] SEL_AND  = 3'b100;
    localparam logic [2:0] SEL_OR   = 3'b101;
    localparam logic [2:0] SEL_XOR  = 3'b110;
    localparam logic [2:0] SEL_NOTA = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // AND/OR destroy information about A, so only these three can be undone
    function automatic logic is_invertible(input logic [2:0] sel);
        return (sel == SEL_ADD) || (sel == SEL_XOR) || (sel == SEL_NOTA);
    endfunction

endpackage

// File: rtl/rev_bit_slice.sv
// One-bit inverse cell: recovers a single bit of A from the matching
// RESULT and B bits, propagating a subtract borrow for ADD.
module rev_bit_slice
    import rev_alu_pkg::*;
(
    input  logic       r,
    input  logic       b,
    input  logic       borrow_in,
    input  logic [2:0] sel,
    output logic       a,
    output logic       borrow_out
);

    always_comb begin
        a          = 1'b0;
        borrow_out = 1'b0;
        case (sel)
            SEL_ADD: begin
                a          = r ^ b ^ borrow_in;
                borrow_out = (~r & (b | borrow_in)) | (b & borrow_in);
            end
            SEL_XOR:  a = r ^ b;
            SEL_NOTA: a = ~r;
            default: begin
                a          = 1'b0;
                borrow_out = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/rev_alu_uncompute.sv
// Bit-serial inverse of the reversible ALU: recovers operand A from
// {COUT, RESULT}, B and the opcode, one bit per clock, LSB first.
//
//   state | meaning
//   IDLE  | ready for a request, in_ready=1
//   SHIFT | recovering A one bit per cycle
//   DONE  | out_a/out_err presented, waiting for out_ready
module rev_alu_uncompute
    import rev_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_cout,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic             out_err
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] a_sh;
    logic [2:0]       sel_q;
    logic             c_q;
    logic             borrow_q;
    logic             err_q;
    logic             a_bit;
    logic             borrow_nxt;

    rev_bit_slice u_slice (
        .r          (r_sh[0]),
        .b          (b_sh[0]),
        .borrow_in  (borrow_q),
        .sel        (sel_q),
        .a          (a_bit),
        .borrow_out (borrow_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = is_invertible(in_sel) ? SHIFT : DONE;
            SHIFT:   if (cnt == LAST_BIT) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            r_sh     <= '0;
            b_sh     <= '0;
            a_sh     <= '0;
            sel_q    <= SEL_ADD;
            c_q      <= 1'b0;
            borrow_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    r_sh     <= in_result;
                    b_sh     <= in_b;
                    c_q      <= in_cout;
                    sel_q    <= in_sel;
                    borrow_q <= 1'b0;
                    cnt      <= '0;
                    a_sh     <= '0;
                    err_q    <= ~is_invertible(in_sel);
                end
                SHIFT: begin
                    r_sh     <= r_sh >> 1;
                    b_sh     <= b_sh >> 1;
                    borrow_q <= borrow_nxt;
                    cnt      <= cnt + 1'b1;
                    // Final borrow must equal COUT, else {C,R}-B left the A range
                    if (cnt == LAST_BIT && sel_q == SEL_ADD && borrow_nxt != c_q) begin
                        err_q <= 1'b1;
                        a_sh  <= '0;
                    end else begin
                        a_sh <= {a_bit, a_sh[WIDTH-1:1]};
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_a     = a_sh;
    assign out_err   = err_q;

endmodule

// File: tb/tb_rev_alu_uncompute.sv
// Self-checking bench for rev_alu_uncompute: directed vectors, backpressure,
// mid-operation reset and a randomized scoreboard against an arithmetic model.
module tb_rev_alu_uncompute;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_result;
    logic         in_cout;
    logic [W-1:0] in_b;
    logic [2:0]   in_sel;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_a;
    logic         out_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] sel;
        logic [7:0] r;
        logic       c;
        logic [7:0] b;
        logic [7:0] a;
        logic       e;
    } vec_t;

    typedef struct packed {
        logic [7:0] a;
        logic       e;
        logic       inv;
    } exp_t;

    rev_alu_uncompute #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_result (in_result),
        .in_cout   (in_cout),
        .in_b      (in_b),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    // A is whatever satisfies {C,R} = A + B (ADD), R = A ^ B (XOR), R = ~A (NOT)
    function automatic void ref_model(input logic [2:0] sel, input logic [7:0] r,
                                      input logic c, input logic [7:0] b,
                                      output logic [7:0] a, output logic e);
        int diff;
        a = 8'h00;
        e = 1'b1;
        case (sel)
            3'b000: begin
                diff = int'({c, r}) - int'(b);
                if (diff >= 0 && diff <= 255) begin
                    a = 8'(diff);
                    e = 1'b0;
                end
            end
            3'b110: begin a = r ^ b; e = 1'b0; end
            3'b111: begin a = ~r;    e = 1'b0; end
            default: ;
        endcase
    endfunction

    // Presents a request, waits for acceptance and for out_valid; lat counts
    // clock edges between the accepting edge and out_valid rising.
    task automatic issue(input logic [2:0] sel, input logic [7:0] r, input logic c,
                         input logic [7:0] b, input bit jitter,
                         output int lat, output logic to);
        int guard;
        @(negedge clk);
        in_valid  = 1'b1;
        in_sel    = sel;
        in_result = r;
        in_cout   = c;
        in_b      = b;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        in_sel    = 3'($urandom);
        in_result = 8'($urandom);
        in_cout   = 1'($urandom);
        in_b      = 8'($urandom);
        lat = 0;
        while (!out_valid && lat < 50) begin
            if (jitter) out_ready = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        out_ready = 1'b0;
        to = !out_valid || guard >= 50;
    endtask

    task automatic complete(input int stall);
        repeat (stall) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++;
        if (out_a !== 8'h00) begin errors++; $display("FAIL reset_out_a: got %h expected 00", out_a); end
        checks++;
        if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err: got %b expected 0", out_err); end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got ready=%b valid=%b expected 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed;
        vec_t v[8];
        int   lat, exp_lat;
        logic to;
        v[0] = '{3'b000, 8'h10, 1'b0, 8'h03, 8'h0D, 1'b0};
        v[1] = '{3'b000, 8'h00, 1'b1, 8'h01, 8'hFF, 1'b0};
        v[2] = '{3'b000, 8'h02, 1'b0, 8'h05, 8'h00, 1'b1};
        v[3] = '{3'b110, 8'h66, 1'b0, 8'hCC, 8'hAA, 1'b0};
        v[4] = '{3'b111, 8'h55, 1'b1, 8'h3C, 8'hAA, 1'b0};
        v[5] = '{3'b100, 8'h88, 1'b0, 8'h11, 8'h00, 1'b1};
        v[6] = '{3'b101, 8'hF0, 1'b1, 8'h0F, 8'h00, 1'b1};
        v[7] = '{3'b010, 8'h7E, 1'b0, 8'h01, 8'h00, 1'b1};
        for (int i = 0; i < 8; i++) begin
            exp_lat = (v[i].sel == 3'b000 || v[i].sel == 3'b110 || v[i].sel == 3'b111) ? W : 0;
            issue(v[i].sel, v[i].r, v[i].c, v[i].b, 1'b0, lat, to);
            checks++;
            if (to !== 1'b0) begin errors++; $display("FAIL dir%0d_timeout: got no out_valid expected out_valid", i); end
            checks++;
            if (lat != exp_lat) begin errors++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, exp_lat); end
            checks++;
            if (out_a !== v[i].a) begin errors++; $display("FAIL dir%0d_out_a: got %h expected %h", i, out_a, v[i].a); end
            checks++;
            if (out_err !== v[i].e) begin errors++; $display("FAIL dir%0d_out_err: got %b expected %b", i, out_err, v[i].e); end
            complete(0);
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL dir%0d_release: got valid=%b ready=%b expected 0 1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_backpressure;
        int   lat;
        logic to;
        issue(3'b000, 8'h10, 1'b0, 8'h03, 1'b0, lat, to);
        // A second request waits at the input while the first is stalled
        in_valid  = 1'b1;
        in_sel    = 3'b110;
        in_result = 8'h66;
        in_b      = 8'hCC;
        in_cout   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_a !== 8'h0D || out_err !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall%0d_hold: got valid=%b a=%h err=%b ready=%b expected 1 0d 0 0",
                         i, out_valid, out_a, out_err, in_ready);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_handshake: got valid=%b ready=%b expected 0 1", out_valid, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_next_accept: got ready=%b expected 0", in_ready); end
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != W) begin errors++; $display("FAIL stall_next_latency: got %0d expected %0d", lat, W); end
        checks++;
        if (out_a !== 8'hAA || out_err !== 1'b0) begin
            errors++;
            $display("FAIL stall_next_result: got a=%h err=%b expected aa 0", out_a, out_err);
        end
        complete(0);
    endtask

    task automatic test_reset_mid;
        int   lat;
        int   seen;
        logic to;
        @(negedge clk);
        in_valid  = 1'b1;
        in_sel    = 3'b000;
        in_result = 8'hF7;
        in_cout   = 1'b0;
        in_b      = 8'h12;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_a !== 8'h00 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state: got ready=%b valid=%b a=%h err=%b expected 1 0 00 0",
                     in_ready, out_valid, out_a, out_err);
        end
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL midrst_no_output: got %0d valid cycles expected 0", seen); end
        issue(3'b110, 8'h0F, 1'b0, 8'hF0, 1'b0, lat, to);
        checks++;
        if (to !== 1'b0 || out_a !== 8'hFF || out_err !== 1'b0) begin
            errors++;
            $display("FAIL midrst_next: got to=%b a=%h err=%b expected 0 ff 0", to, out_a, out_err);
        end
        complete(0);
    endtask

    task automatic test_random;
        exp_t       exp_q[$];
        exp_t       ex;
        logic [2:0] sel;
        logic [7:0] r, b, ea;
        logic       c, ee;
        int         lat, pick;
        logic       to;
        for (int n = 0; n < 60; n++) begin
            pick = int'($urandom_range(0, 3));
            sel  = (pick == 2) ? 3'b110 : (pick == 3) ? 3'b111 : 3'b000;
            b    = 8'($urandom);
            if (sel == 3'b000 && $urandom_range(0, 1) == 1) begin
                // Consistent sum from a chosen A, so the non-error path is well covered
                {c, r} = 9'(int'($urandom_range(0, 255)) + int'(b));
            end else begin
                r = 8'($urandom);
                c = 1'($urandom);
            end
            ref_model(sel, r, c, b, ea, ee);
            exp_q.push_back('{ea, ee, 1'b1});
            issue(sel, r, c, b, 1'b1, lat, to);
            ex = exp_q.pop_front();
            checks++;
            if (to !== 1'b0) begin errors++; $display("FAIL rnd%0d_timeout: got no out_valid expected out_valid", n); end
            checks++;
            if (lat != W) begin errors++; $display("FAIL rnd%0d_latency: got %0d expected %0d", n, lat, W); end
            checks++;
            if (out_a !== ex.a || out_err !== ex.e) begin
                errors++;
                $display("FAIL rnd%0d_result sel=%b r=%h c=%b b=%h: got a=%h err=%b expected a=%h err=%b",
                         n, sel, r, c, b, out_a, out_err, ex.a, ex.e);
            end
            complete(int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_result = '0;
        in_cout   = 1'b0;
        in_b      = '0;
        in_sel    = 3'b000;
        out_ready = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
